tiny_dmem_responder: RTL and testbench

- Data-memory responder for the tiny CPU's load/store path. It is the target end of the CPU's LW/SW interface.
- Accepts one request at a time over a valid/ready request channel, inserts a configurable number of wait states, then returns a response over a valid/ready response channel.
- Holds a word-addressed data RAM and one memory-mapped LED register that drives the board RGB LED.

---
 rtl/tiny_dmem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_tiny_dmem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dmem_responder.sv
// ---------------------------------------------------------------------------
// tiny_dmem_responder
//
// Target end of the tiny CPU's load/store path. It accepts one request at a
// time on a valid/ready request channel and waits WAIT_STATES extra cycles.
// It then performs the access against a word-addressed RAM or the LED
// register, and holds the registered result on a valid/ready response
// channel until the requester takes it.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_wdata, req_wstrb  store data and byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load data (0 for stores/errors), access error
//   led_red/green/blue    LED register bits 0/1/2
//
// Optional feature (macro TINY_DMEM_ACCESS_COUNT_EN):
//   Adds a 32-bit access counter at LED_ADDR+4. It counts error-free
//   responses. A store to it clears it.
// ---------------------------------------------------------------------------
module tiny_dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] LED_ADDR    = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        led_red,
  output logic        led_green,
  output logic        led_blue
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  led_q, led_d;

`ifdef TINY_DMEM_ACCESS_COUNT_EN
  localparam logic [31:0] CNT_ADDR = LED_ADDR + 32'd4;
  logic [31:0] acc_q, acc_d;
  // Marks a response whose access cleared the counter. That handshake must
  // not bump the freshly cleared count.
  logic        clr_q, clr_d;
`endif

  // Decode always works on the latched address, never the live inputs.
  logic          access;
  logic          misaligned;
  logic          is_ram;
  logic          is_led;
  logic          ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;

  assign access     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign is_ram     = (addr_q < RAM_BYTES);
  assign is_led     = (addr_q == LED_ADDR);
  assign ram_idx    = addr_q[AW+1:2];
  assign ram_we     = access && we_q && !misaligned && is_ram;

  // One byte-wide array per lane. Each lane then has a single write
  // enable, and no read-modify-write is needed for partial stores.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
      if (ram_we && wstrb_q[gi]) begin
        mem[ram_idx] <= wdata_q[8*gi +: 8];
      end
    end

    assign ram_word[8*gi +: 8] = mem[ram_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
`ifdef TINY_DMEM_ACCESS_COUNT_EN
    acc_d   = acc_q;
    clr_d   = clr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          rdata_d = 32'd0;
          err_d   = 1'b0;
`ifdef TINY_DMEM_ACCESS_COUNT_EN
          clr_d   = 1'b0;
`endif
          if (misaligned) begin
            err_d = 1'b1;
          end else if (is_ram) begin
            if (!we_q) rdata_d = ram_word;
          end else if (is_led) begin
            if (we_q) begin
              if (wstrb_q[0]) led_d = wdata_q[2:0];
            end else begin
              rdata_d = {29'd0, led_q};
            end
`ifdef TINY_DMEM_ACCESS_COUNT_EN
          end else if (addr_q == CNT_ADDR) begin
            if (we_q) begin
              acc_d = 32'd0;
              clr_d = 1'b1;
            end else begin
              rdata_d = acc_q;
            end
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
`ifdef TINY_DMEM_ACCESS_COUNT_EN
          if (!err_q && !clr_q) acc_d = acc_q + 32'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      led_q   <= 3'd0;
`ifdef TINY_DMEM_ACCESS_COUNT_EN
      acc_q   <= 32'd0;
      clr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
`ifdef TINY_DMEM_ACCESS_COUNT_EN
      acc_q   <= acc_d;
      clr_q   <= clr_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign led_red   = led_q[0];
  assign led_green = led_q[1];
  assign led_blue  = led_q[2];

endmodule

// File: tb/tb_tiny_dmem_responder.sv
module tb_tiny_dmem_responder;

  localparam int          DEPTH_WORDS = 256;
  localparam int          WAIT_STATES = 1;
  localparam logic [31:0] LED_ADDR    = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        led_red, led_green, led_blue;

  always #5 CLK = ~CLK;

  tiny_dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WAIT_STATES(WAIT_STATES),
    .LED_ADDR(LED_ADDR)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [2:0]  exp_led;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                              input logic exp_err, input logic [2:0] exp_led);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_led = exp_led;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transaction: present at a falling edge, accept on the next
  // rising edge, count edges to rsp_valid, then handshake the response.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output logic err, output int lat);
    lat = -1;
    rdata = 32'hxxxx_xxxx;
    err = 1'bx;
    @(negedge CLK);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge CLK);
    #1;
    // Scramble the request inputs; the latched copy must be used.
    req_valid = 1'b0; req_we = ~we; req_addr = 32'h4; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    for (int k = 1; k <= 50; k++) begin
      if (rsp_valid) break;
      @(posedge CLK);
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid never rose, expected within 50 edges");
    end else begin
      rdata = rsp_rdata;
      err = rsp_err;
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
      check("idle_after_handshake", {30'd0, req_ready, rsp_valid}, 32'd2);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held_rdata;

  initial begin
    // Table: store/load pairs, byte lanes, LED, error cases, boundaries.
    add(1, 32'h8,            32'h0000_002A, 4'hF, 32'h0,          0, 3'd0);
    add(0, 32'h8,            32'h0,         4'h0, 32'h0000_002A,  0, 3'd0);
    add(1, 32'h8,            32'hAABB_CCDD, 4'hF, 32'h0,          0, 3'd0);
    add(1, 32'h8,            32'h1122_3344, 4'h5, 32'h0,          0, 3'd0);
    add(0, 32'h8,            32'h0,         4'hF, 32'hAA22_CC44,  0, 3'd0);
    add(1, LED_ADDR,         32'hFFFF_FFFD, 4'hF, 32'h0,          0, 3'd5);
    add(0, LED_ADDR,         32'h0,         4'h0, 32'h0000_0005,  0, 3'd5);
    add(0, 32'h6,            32'h0,         4'h0, 32'h0,          1, 3'd5);
    add(0, 32'h400,          32'h0,         4'h0, 32'h0,          1, 3'd5);
    add(1, 32'h2,            32'hFFFF_FFFF, 4'hF, 32'h0,          1, 3'd5);
    add(1, 32'h400,          32'hFFFF_FFFF, 4'hF, 32'h0,          1, 3'd5);
    add(0, 32'h8,            32'h0,         4'h0, 32'hAA22_CC44,  0, 3'd5);
    add(1, LED_ADDR,         32'h0000_0002, 4'hE, 32'h0,          0, 3'd5);
    add(0, LED_ADDR,         32'h0,         4'h0, 32'h0000_0005,  0, 3'd5);
    add(1, 32'h3FC,          32'h1234_5678, 4'hF, 32'h0,          0, 3'd5);
    add(0, 32'h3FC,          32'h0,         4'h0, 32'h1234_5678,  0, 3'd5);
    add(1, 32'h0,            32'hCAFE_F00D, 4'hF, 32'h0,          0, 3'd5);
    add(1, 32'h0,            32'h0,         4'h0, 32'h0,          0, 3'd5);
    add(0, 32'h0,            32'h0,         4'h0, 32'hCAFE_F00D,  0, 3'd5);
    add(1, 32'h10,           32'h0000_0001, 4'hF, 32'h0,          0, 3'd5);
`ifndef TINY_DMEM_ACCESS_COUNT_EN
    add(0, LED_ADDR + 32'd4, 32'h0,         4'h0, 32'h0,          1, 3'd5);
    add(1, LED_ADDR + 32'd4, 32'h0,         4'hF, 32'h0,          1, 3'd5);
`endif

    // Reset state, checked while reset is held.
    #12;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("reset_leds",      {29'd0, led_blue, led_green, led_red}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat);
      $display("txn %0d: we=%0b addr=0x%08h wdata=0x%08h wstrb=0x%h -> rdata=0x%08h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAIT_STATES + 1));
      check($sformatf("vec%0d_leds", i), {29'd0, led_blue, led_green, led_red},
            {29'd0, vecs[i].exp_led});
    end

`ifdef TINY_DMEM_ACCESS_COUNT_EN
    // Clear, then two loads. The clearing store is not counted. Each load
    // sees the count from before its own handshake.
    do_txn(1, LED_ADDR + 32'd4, 32'h1234_5678, 4'h0, rd, er, lat);
    $display("txn cnt_clear: rdata=0x%08h err=%0b", rd, er);
    check("cnt_clear_err", {31'd0, er}, 32'd0);
    do_txn(0, LED_ADDR + 32'd4, 32'h0, 4'h0, rd, er, lat);
    $display("txn cnt_load1: rdata=0x%08h err=%0b", rd, er);
    check("cnt_load1", rd, 32'd0);
    do_txn(0, 32'h6, 32'h0, 4'h0, rd, er, lat);
    $display("txn cnt_errload: rdata=0x%08h err=%0b", rd, er);
    do_txn(0, LED_ADDR + 32'd4, 32'h0, 4'h0, rd, er, lat);
    $display("txn cnt_load2: rdata=0x%08h err=%0b", rd, er);
    check("cnt_load2", rd, 32'd1);
`endif

    // Back-pressure: hold rsp_ready low. A competing store to 0x8 must be
    // ignored, and the response must stay stable.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_wdata = 32'h0; req_wstrb = 4'h0;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge CLK);
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("bp_latency", 32'(lat), 32'(WAIT_STATES + 1));
    held_rdata = rsp_rdata;
    check("bp_rdata", held_rdata, 32'hAA22_CC44);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8;
      req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
      @(posedge CLK);
      #1;
      $display("bp cycle %0d: rsp_valid=%0b rdata=0x%08h err=%0b req_ready=%0b",
               c, rsp_valid, rsp_rdata, rsp_err, req_ready);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata_stable", rsp_rdata, held_rdata);
      check("bp_err_stable", {31'd0, rsp_err}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    check("bp_back_to_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
    do_txn(0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    $display("txn bp_verify: rdata=0x%08h err=%0b", rd, er);
    check("bp_store_ignored", rd, 32'hAA22_CC44);

    // Reset during WAIT of a store to 0x10, which holds 0x1. The store is
    // discarded and the LEDs return to 0.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    RST_N = 1'b0;
    #2;
    $display("reset mid-op: rsp_valid=%0b req_ready=%0b leds=%0b%0b%0b",
             rsp_valid, req_ready, led_blue, led_green, led_red);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_leds", {29'd0, led_blue, led_green, led_red}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    do_txn(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    $display("txn rst_verify: rdata=0x%08h err=%0b", rd, er);
    check("rst_store_discarded", rd, 32'h0000_0001);
    check("rst_verify_err", {31'd0, er}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
